instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//  Producer side of the instruction-register load interface: fetches 32-bit words from instruction memory and drives instr_out/ir_we.
//  Owns the PC, runs a req/ack handshake to memory, pulses ir_we one cycle per completed fetch, and accepts PC redirects.
//  Sits between instruction memory and InstructionRegister.
// PARAMETERS
//  RESET_PC        32'h0000_0000  PC value loaded on reset (word aligned)
//  TIMEOUT_CYCLES  16             WAIT cycles before a fetch is abandoned (IFU_TIMEOUT_EN only)
// PORTS
//  clk        in   1   single clock; all state updates on posedge
//  reset      in   1   synchronous, active-high reset
//  fetch_en   in   1   request one fetch at current PC (sampled in IDLE only)
//  pc_we      in   1   redirect strobe (branch/jump)
//  pc_in      in   32  redirect target; bits [1:0] ignored, forced 0
//  mem_req    out  1   memory request, held until mem_ack or abort
//  mem_addr   out  32  fetch address, stable while mem_req=1
//  mem_ack    in   1   memory data valid this cycle (only meaningful while mem_req=1)
//  mem_rdata  in   32  instruction word, sampled when mem_ack=1
//  instr_out  out  32  last delivered instruction (drives IR instr_in)
//  ir_we      out  1   one-cycle pulse: instr_out is new this cycle
//  pc_out     out  32  current PC (address of next fetch)
//  busy       out  1   1 when state != IDLE
//  fetch_err  out  1   one-cycle pulse on fetch timeout (0 without IFU_TIMEOUT_EN)
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, mem_req=0, mem_addr=0, instr_out=0, ir_we=0, busy=0, fetch_err=0, squash=0.
//   Reset during WAIT aborts: mem_req low after that edge, no ir_we.
//  All outputs registered. FSM states: IDLE, WAIT, DELIVER.
//  IDLE: fetch_en=1 -> mem_req<=1, mem_addr<=pc (or {pc_in[31:2],2'b00} if pc_we same cycle), -> WAIT.
//   pc_we alone -> pc<={pc_in[31:2],2'b00}, stay IDLE.
//  WAIT: mem_req, mem_addr held. On mem_ack: mem_req<=0;
//   squash=0 -> instr_out<=mem_rdata, ir_we<=1, pc<=pc+4 (mod 2^32, FFFF_FFFC wraps to 0), -> DELIVER;
//   squash=1 -> word discarded, instr_out/pc unchanged, squash<=0, -> IDLE.
//  pc_we in WAIT: pc<=pc_in aligned, squash<=1; the in-flight access still completes (no mid-flight drop of mem_req).
//  pc_we and mem_ack same cycle: redirect wins; word discarded, pc<=pc_in, -> IDLE.
//  DELIVER: ir_we<=0 next edge, -> IDLE; fetch_en here is ignored (must be re-asserted in IDLE).
//   pc_we here -> pc<=pc_in (overrides the +4).
//  Latency: fetch_en at edge N -> mem_req high after N; mem_ack sampled at edge M -> ir_we=1, instr_out valid for cycle after M.
//   Back-to-back minimum: 3 cycles per instruction with 1-cycle-ack memory.
//  ir_we never high two consecutive cycles; instr_out changes only together with ir_we=1.
//  mem_ack while mem_req=0: ignored.
// CONFIGURATION
//  IFU_TIMEOUT_EN defined: counter cleared on entry to WAIT, +1 per WAIT cycle without mem_ack;
//   reaching TIMEOUT_CYCLES -> mem_req<=0, fetch_err<=1 one cycle, pc unchanged, squash cleared, -> IDLE.
//   mem_ack in same cycle as the limit is accepted normally.
//  Not defined: no counter; WAIT holds indefinitely; fetch_err tied 0.
// TESTING
//  1. reset, RESET_PC=0; fetch_en, mem_ack 1 cycle later with rdata=32'h8C22_0004 -> ir_we 1 cycle, instr_out=8C220004, pc_out=4.
//  2. three fetches, ack delays 1/3/0 cycles -> mem_addr 0,4,8; exactly 3 ir_we pulses; pc_out=C; mem_addr stable while mem_req.
//  3. pc_we=1, pc_in=32'h0000_0103 during WAIT, then ack -> no ir_we, instr_out unchanged, pc_out=0000_0100; next fetch addr=100.
//  4. pc_we and mem_ack same cycle (pc_in=40) -> word dropped, pc_out=40, IDLE; pc=FFFF_FFFC fetch -> pc_out wraps to 0.
//  5. reset asserted in WAIT -> next cycle mem_req=0, busy=0, pc_out=RESET_PC, no ir_we.
//  6. IFU_TIMEOUT_EN, no ack for 16 cycles -> fetch_err pulse, mem_req=0, pc unchanged; undefined build -> mem_req held 100 cycles.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches words over a req/ack memory port and pulses ir_we per delivered word.
// Optional fetch timeout is enabled by defining IFU_TIMEOUT_EN.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_en,
    input  logic        pc_we,
    input  logic [31:0] pc_in,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] instr_out,
    output logic        ir_we,
    output logic [31:0] pc_out,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DELIVER = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

    state_e      state_r;
    logic        squash_r;
    logic [31:0] pc_in_aligned_s;
    logic        unused_s;

    assign pc_in_aligned_s = {pc_in[31:2], 2'b00};
    assign unused_s        = ^{pc_in[1:0], (TIMEOUT_CYCLES != 32'd0)};

`ifdef IFU_TIMEOUT_EN
    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 32'd1);

    logic [TMO_W-1:0] tmo_cnt_r;
    logic             tmo_hit_s;

    // Timeout fires on the WAIT cycle that would make the no-ack count reach the limit.
    always_comb begin
        tmo_hit_s = 1'b0;
        if (state_r == ST_WAIT && !mem_ack && tmo_cnt_r == TMO_LAST) begin
            tmo_hit_s = 1'b1;
        end else begin
            tmo_hit_s = 1'b0;
        end
    end

    // Count WAIT cycles without an acknowledge; cleared whenever a fetch is launched.
    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_IDLE) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
        end else if (state_r == ST_WAIT && !mem_ack) begin
            tmo_cnt_r <= tmo_cnt_r + {{(TMO_W-1){1'b0}}, 1'b1};
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end
`else
    logic tmo_hit_s;
    assign tmo_hit_s = 1'b0;
`endif

    // Fetch FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pc_out    <= RESET_PC_ALIGNED;
            mem_req   <= 1'b0;
            mem_addr  <= 32'h0000_0000;
            instr_out <= 32'h0000_0000;
            ir_we     <= 1'b0;
            busy      <= 1'b0;
            fetch_err <= 1'b0;
            squash_r  <= 1'b0;
        end else begin
            ir_we     <= 1'b0;
            fetch_err <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (fetch_en) begin
                        mem_req  <= 1'b1;
                        busy     <= 1'b1;
                        state_r  <= ST_WAIT;
                        squash_r <= 1'b0;
                        if (pc_we) begin
                            mem_addr <= pc_in_aligned_s;
                            pc_out   <= pc_in_aligned_s;
                        end else begin
                            mem_addr <= pc_out;
                        end
                    end else if (pc_we) begin
                        pc_out <= pc_in_aligned_s;
                    end else begin
                        pc_out <= pc_out;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack && pc_we) begin
                        // Redirect beats the returning word.
                        mem_req  <= 1'b0;
                        busy     <= 1'b0;
                        pc_out   <= pc_in_aligned_s;
                        squash_r <= 1'b0;
                        state_r  <= ST_IDLE;
                    end else if (mem_ack) begin
                        mem_req  <= 1'b0;
                        squash_r <= 1'b0;
                        if (squash_r) begin
                            busy    <= 1'b0;
                            state_r <= ST_IDLE;
                        end else begin
                            instr_out <= mem_rdata;
                            ir_we     <= 1'b1;
                            pc_out    <= pc_out + 32'd4;
                            state_r   <= ST_DELIVER;
                        end
                    end else if (tmo_hit_s) begin
                        mem_req   <= 1'b0;
                        busy      <= 1'b0;
                        fetch_err <= 1'b1;
                        squash_r  <= 1'b0;
                        state_r   <= ST_IDLE;
                        if (pc_we) begin
                            pc_out <= pc_in_aligned_s;
                        end else begin
                            pc_out <= pc_out;
                        end
                    end else if (pc_we) begin
                        // In-flight access still completes; its word is dropped.
                        pc_out   <= pc_in_aligned_s;
                        squash_r <= 1'b1;
                    end else begin
                        pc_out <= pc_out;
                    end
                end
                ST_DELIVER: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                    if (pc_we) begin
                        pc_out <= pc_in_aligned_s;
                    end else begin
                        pc_out <= pc_out;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    mem_req  <= 1'b0;
                    busy     <= 1'b0;
                    squash_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: stimulus pushes expected deliveries, a monitor pops on ir_we.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_en = 1'b0;
    logic        pc_we = 1'b0;
    logic [31:0] pc_in = 32'h0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] instr_out;
    logic        ir_we;
    logic [31:0] pc_out;
    logic        busy;
    logic        fetch_err;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   passes = 0;
    int   ir_we_cnt = 0;

    logic        prev_reset = 1'b1;
    logic        prev_ir_we = 1'b0;
    logic        prev_req = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] prev_instr = 32'h0;

    instruction_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .pc_we(pc_we), .pc_in(pc_in),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .instr_out(instr_out), .ir_we(ir_we), .pc_out(pc_out), .busy(busy), .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every ir_we and checks protocol invariants each cycle.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && !prev_reset) begin
            if (ir_we) begin
                ir_we_cnt++;
                chk1("ir_we_gap", prev_ir_we, 1'b0);
                if (sb_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_ir_we: instr_out %h with nothing expected", instr_out);
                end else begin
                    e = sb_q.pop_front();
                    chk("instr_out", instr_out, e.instr);
                    chk("pc_after_fetch", pc_out, e.pc);
                end
            end else begin
                chk("instr_hold", instr_out, prev_instr);
            end
            if (mem_req && prev_req) chk("mem_addr_stable", mem_addr, prev_addr);
        end
        prev_reset = reset;
        prev_ir_we = ir_we;
        prev_req   = mem_req;
        prev_addr  = mem_addr;
        prev_instr = instr_out;
    end

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    task automatic start_fetch(input logic [31:0] exp_addr);
        fetch_en = 1'b1;
        step();
        fetch_en = 1'b0;
        chk1("mem_req_rise", mem_req, 1'b1);
        chk("mem_addr", mem_addr, exp_addr);
        chk1("busy_wait", busy, 1'b1);
    endtask

    task automatic finish_fetch(input logic [31:0] data, input logic [31:0] exp_pc);
        sb_q.push_back({data, exp_pc});
        mem_ack   = 1'b1;
        mem_rdata = data;
        step();
        mem_ack = 1'b0;
        chk1("mem_req_drop", mem_req, 1'b0);
        chk1("ir_we_pulse", ir_we, 1'b1);
        step();
        chk1("ir_we_clear", ir_we, 1'b0);
        chk1("busy_idle", busy, 1'b0);
    endtask

    task automatic do_fetch(input logic [31:0] addr, input logic [31:0] data,
                            input int delay, input logic [31:0] exp_pc);
        start_fetch(addr);
        for (int i = 0; i < delay; i++) begin
            step();
            chk1("mem_req_held", mem_req, 1'b1);
        end
        finish_fetch(data, exp_pc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int hi;
        int errs;

        // Reset state
        do_reset();
        chk1("rst_mem_req", mem_req, 1'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk1("rst_ir_we", ir_we, 1'b0);
        chk("rst_pc", pc_out, 32'h0);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_fetch_err", fetch_err, 1'b0);

        // Single fetch with one-cycle ack
        do_fetch(32'h0, 32'h8C22_0004, 0, 32'h4);
        chk("t1_pc", pc_out, 32'h4);

        // Three fetches with ack delays 1/3/0
        do_reset();
        base = ir_we_cnt;
        do_fetch(32'h0, 32'hAAAA_0001, 1, 32'h4);
        do_fetch(32'h4, 32'hBBBB_0002, 3, 32'h8);
        do_fetch(32'h8, 32'hCCCC_0003, 0, 32'hC);
        chk("t2_pulses", 32'(ir_we_cnt - base), 32'd3);
        chk("t2_pc", pc_out, 32'hC);

        // Redirect during WAIT squashes the returning word
        do_reset();
        do_fetch(32'h0, 32'h1111_1111, 0, 32'h4);
        start_fetch(32'h4);
        pc_we = 1'b1;
        pc_in = 32'h0000_0103;
        step();
        pc_we = 1'b0;
        chk("t3_pc_redirect", pc_out, 32'h100);
        chk1("t3_req_held", mem_req, 1'b1);
        chk("t3_addr_held", mem_addr, 32'h4);
        mem_ack   = 1'b1;
        mem_rdata = 32'hDEAD_BEEF;
        step();
        mem_ack = 1'b0;
        chk1("t3_req_drop", mem_req, 1'b0);
        chk1("t3_busy", busy, 1'b0);
        chk1("t3_no_ir_we", ir_we, 1'b0);
        chk("t3_instr_kept", instr_out, 32'h1111_1111);
        chk("t3_pc", pc_out, 32'h100);
        do_fetch(32'h100, 32'h2222_2222, 1, 32'h104);

        // Redirect and ack in the same cycle
        start_fetch(32'h104);
        pc_we     = 1'b1;
        pc_in     = 32'h0000_0040;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBAD0_BAD0;
        step();
        pc_we   = 1'b0;
        mem_ack = 1'b0;
        chk("t4_pc", pc_out, 32'h40);
        chk1("t4_busy", busy, 1'b0);
        chk1("t4_req", mem_req, 1'b0);
        chk1("t4_no_ir_we", ir_we, 1'b0);

        // Stray ack while idle is ignored
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk1("stray_ack_busy", busy, 1'b0);
        chk1("stray_ack_req", mem_req, 1'b0);

        // PC wrap at the top of the address space
        pc_we = 1'b1;
        pc_in = 32'hFFFF_FFFF;
        step();
        pc_we = 1'b0;
        chk("t4_pc_top", pc_out, 32'hFFFF_FFFC);
        chk1("t4_idle", busy, 1'b0);
        do_fetch(32'hFFFF_FFFC, 32'h3333_3333, 2, 32'h0);
        chk("t4_wrap", pc_out, 32'h0);

        // Redirect in DELIVER overrides +4, fetch_en there is ignored
        start_fetch(32'h0);
        sb_q.push_back({32'h4444_4444, 32'h4});
        mem_ack   = 1'b1;
        mem_rdata = 32'h4444_4444;
        step();
        mem_ack  = 1'b0;
        fetch_en = 1'b1;
        pc_we    = 1'b1;
        pc_in    = 32'h0000_0200;
        step();
        fetch_en = 1'b0;
        pc_we    = 1'b0;
        chk("deliver_pc", pc_out, 32'h200);
        chk1("deliver_no_fetch", busy, 1'b0);
        chk1("deliver_no_req", mem_req, 1'b0);

        // Ack arriving on the 16th WAIT cycle is accepted in either build
        do_fetch(32'h200, 32'h5555_5555, 15, 32'h204);

        // Reset during WAIT aborts the access
        start_fetch(32'h204);
        reset = 1'b1;
        step();
        chk1("t5_req", mem_req, 1'b0);
        chk1("t5_busy", busy, 1'b0);
        chk("t5_pc", pc_out, 32'h0);
        chk1("t5_ir_we", ir_we, 1'b0);
        reset = 1'b0;
        step();

        // Memory never answers
        start_fetch(32'h0);
        hi   = 1;
        errs = 0;
`ifdef IFU_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            step();
            if (fetch_err) break;
            if (mem_req) hi++;
        end
        chk("t6_req_cycles", 32'(hi), 32'd16);
        chk1("t6_fetch_err", fetch_err, 1'b1);
        chk1("t6_req_drop", mem_req, 1'b0);
        chk1("t6_busy", busy, 1'b0);
        chk("t6_pc", pc_out, 32'h0);
        step();
        chk1("t6_err_pulse", fetch_err, 1'b0);
        do_fetch(32'h0, 32'h6666_6666, 0, 32'h4);
`else
        for (int i = 0; i < 100; i++) begin
            step();
            if (mem_req) hi++;
            if (fetch_err) errs++;
        end
        chk("t6_req_held", 32'(hi), 32'd101);
        chk("t6_no_fetch_err", 32'(errs), 32'd0);
        finish_fetch(32'h6666_6666, 32'h4);
`endif

        chk("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
